// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns a Memory-stage access into a single bus
// transaction, stalls the pipeline while it is outstanding, and extends load data.
module lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallLSU,
    output logic        LsuExcM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  dbgState
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } stateT;

    stateT             state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       addrReg;
    logic              weReg;
    logic [2:0]        f3Reg;
    logic [31:0]       wdataReg;
    logic [3:0]        beReg;
    logic [31:0]       readData;
    logic              busErr;

    logic        accValid;
    logic        f3Legal;
    logic        misaligned;
    logic        accOk;
    logic        timeoutHit;
    logic [3:0]  beNext;
    logic [31:0] wdataNext;
    logic [7:0]  rdByte;
    logic [15:0] rdHalf;
    logic [31:0] loadExt;

    // Bus handshake: mem_req is held high with mem_addr/mem_we/mem_wdata/mem_be
    // stable until a cycle in which mem_gnt is high, which accepts the request at
    // that clock edge. mem_rvalid is a one-cycle strobe qualifying mem_rdata and is
    // honoured only while waiting for load data; at any other time it is ignored.
    assign accValid   = MemWriteM | (ResultSrcM == 2'b01);
    assign misaligned = ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                        ((funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
    assign accOk      = accValid && f3Legal && !misaligned;
    assign timeoutHit = (cnt == CNT_W'(TIMEOUT));

    always_comb begin
        f3Legal = 1'b0;
        if (MemWriteM) begin
            f3Legal = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010);
        end else begin
            f3Legal = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010) ||
                      (funct3M == 3'b100) || (funct3M == 3'b101);
        end
    end

    // Store lanes are formatted at capture time so the bus sees only registers.
    always_comb begin
        beNext    = 4'b1111;
        wdataNext = 32'd0;
        if (MemWriteM) begin
            case (funct3M[1:0])
                2'b00: begin
                    beNext    = 4'b0001 << ALUResultM[1:0];
                    wdataNext = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    beNext    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                    wdataNext = {2{WriteDataM[15:0]}};
                end
                default: begin
                    beNext    = 4'b1111;
                    wdataNext = WriteDataM;
                end
            endcase
        end
    end

    always_comb begin
        rdByte = mem_rdata[7:0];
        case (addrReg[1:0])
            2'b00:   rdByte = mem_rdata[7:0];
            2'b01:   rdByte = mem_rdata[15:8];
            2'b10:   rdByte = mem_rdata[23:16];
            default: rdByte = mem_rdata[31:24];
        endcase
        rdHalf = addrReg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3Reg)
            3'b000:  loadExt = {{24{rdByte[7]}}, rdByte};
            3'b100:  loadExt = {24'd0, rdByte};
            3'b001:  loadExt = {{16{rdHalf[15]}}, rdHalf};
            3'b101:  loadExt = {16'd0, rdHalf};
            default: loadExt = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            addrReg  <= 32'd0;
            weReg    <= 1'b0;
            f3Reg    <= 3'd0;
            wdataReg <= 32'd0;
            beReg    <= 4'd0;
            readData <= 32'd0;
            busErr   <= 1'b0;
        end else begin
            busErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (accOk) begin
                        addrReg  <= ALUResultM;
                        weReg    <= MemWriteM;
                        f3Reg    <= funct3M;
                        wdataReg <= wdataNext;
                        beReg    <= beNext;
                        cnt      <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // Saturating keeps a grant taken at the limit from escaping the timeout.
                    cnt <= timeoutHit ? cnt : cnt + 1'b1;
                    if (mem_gnt) begin
                        if (weReg) begin
                            readData <= 32'd0;
                            state    <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (timeoutHit) begin
                        readData <= 32'd0;
                        busErr   <= 1'b1;
                        state    <= ERR;
                    end
                end
                WAIT: begin
                    cnt <= timeoutHit ? cnt : cnt + 1'b1;
                    if (mem_rvalid) begin
                        readData <= loadExt;
                        state    <= DONE;
                    end else if (timeoutHit) begin
                        readData <= 32'd0;
                        busErr   <= 1'b1;
                        state    <= ERR;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign StallLSU  = !reset && (((state == IDLE) && accOk) || (state == REQ) || (state == WAIT));
    assign LsuExcM   = !reset && (state == IDLE) && accValid && !accOk;
    assign mem_req   = !reset && (state == REQ);
    assign mem_we    = weReg;
    assign mem_addr  = {addrReg[31:2], 2'b00};
    assign mem_wdata = wdataReg;
    assign mem_be    = beReg;
    assign ReadDataM = readData;
    assign BusErrM   = busErr;
    assign dbgState  = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized accesses
// against an arithmetic reference of access legality, lane formatting and timeout.
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m;
  logic [31:0] write_data_m;
  logic [31:0] read_data_m;
  logic        stall_lsu;
  logic        lsu_exc_m;
  logic        bus_err_m;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [2:0]  dbg_state;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'd0;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .MemWriteM(mem_write_m), .ResultSrcM(result_src_m), .funct3M(funct3_m),
    .ALUResultM(alu_result_m), .WriteDataM(write_data_m),
    .ReadDataM(read_data_m), .StallLSU(stall_lsu), .LsuExcM(lsu_exc_m), .BusErrM(bus_err_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbgState(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int unsigned size_bytes(input logic [2:0] f3);
    return 32'd1 << (int'(f3) % 4);
  endfunction

  function automatic logic ref_ok(input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                                  input logic [31:0] addr);
    logic legal;
    if (!(mw || rs == 2'b01)) return 1'b0;
    if (mw) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return legal && ((addr % size_bytes(f3)) == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int unsigned nb;
    logic [31:0] raw;
    logic [31:0] mask;
    nb  = size_bytes(f3);
    raw = rdata >> (8 * (addr % 4));
    if (nb < 4) begin
      mask = (32'd1 << (8 * nb)) - 32'd1;
      raw  = raw & mask;
      if (f3 < 3'd4 && raw[8*nb-1]) raw = raw | ~mask;
    end
    return raw;
  endfunction

  function automatic logic [3:0] ref_be(input logic mw, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned nb;
    if (!mw) return 4'hF;
    nb = size_bytes(f3);
    return 4'(((32'd1 << nb) - 32'd1) << (addr % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] o;
    int unsigned nb;
    nb = size_bytes(f3);
    o  = 32'd0;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % nb) +: 8];
    return o;
  endfunction

  // driver tasks
  task automatic idle_inputs();
    mem_write_m  = 1'b0;
    result_src_m = 2'b00;
    funct3_m     = 3'd0;
    alu_result_m = 32'd0;
    write_data_m = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge with the DUT idle; gd = REQ cycle index
  // of the grant, rd = WAIT cycle index of rvalid.
  task automatic do_access(input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int gd, input int rd, input logic [31:0] rdata,
                           input logic use_exp, input logic [31:0] exp_rd);
    logic ok_acc, ok_bus, in_req;
    int   n_req, n_busy, j_abort;
    mem_write_m = mw; result_src_m = rs; funct3_m = f3; alu_result_m = addr; write_data_m = wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    ok_acc = ref_ok(mw, rs, f3, addr);
    @(negedge clk);
    if (!(mw || rs == 2'b01)) begin
      check_val("noacc_stall", 32'(stall_lsu), 32'd0);
      check_val("noacc_exc", 32'(lsu_exc_m), 32'd0);
      next_cycle();
      idle_inputs();
      return;
    end
    if (!ok_acc) begin
      check_val("exc_pulse", 32'(lsu_exc_m), 32'd1);
      check_val("exc_stall", 32'(stall_lsu), 32'd0);
      check_val("exc_req", 32'(mem_req), 32'd0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check_val("exc_end", 32'(lsu_exc_m), 32'd0);
      check_val("exc_req_after", 32'(mem_req), 32'd0);
      check_val("exc_rd_hold", read_data_m, last_rd);
      next_cycle();
      return;
    end
    check_val("start_stall", 32'(stall_lsu), 32'd1);
    check_val("start_exc", 32'(lsu_exc_m), 32'd0);
    n_req = (gd <= TO) ? gd + 1 : TO + 1;
    if (mw) begin
      ok_bus = (gd <= TO);
      n_busy = n_req;
    end else if (gd > TO) begin
      ok_bus = 1'b0;
      n_busy = n_req;
    end else begin
      ok_bus  = (rd == 0) || (gd + rd < TO);
      j_abort = (TO - gd - 1 > 0) ? TO - gd - 1 : 0;
      n_busy  = n_req + (ok_bus ? rd + 1 : j_abort + 1);
    end
    if (use_exp)     exp_q.push_back(exp_rd);
    else if (!ok_bus || mw) exp_q.push_back(32'd0);
    else             exp_q.push_back(ref_load(f3, addr, rdata));
    next_cycle();
    // pipeline inputs wander while the access is held in the captured registers
    mem_write_m = 1'b0; result_src_m = 2'b00;
    funct3_m = 3'($urandom_range(0, 7)); alu_result_m = $urandom; write_data_m = $urandom;
    for (int c = 0; c < n_busy; c++) begin
      in_req  = (c < n_req);
      mem_gnt = in_req && (c == gd);
      if (in_req) begin
        mem_rvalid = ($urandom_range(0, 3) == 0);
        mem_rdata  = $urandom;
      end else begin
        mem_rvalid = ((c - n_req) == rd);
        mem_rdata  = mem_rvalid ? rdata : $urandom;
      end
      @(negedge clk);
      check_val("busy_stall", 32'(stall_lsu), 32'd1);
      check_val("busy_req", 32'(mem_req), 32'(in_req));
      check_val("busy_buserr", 32'(bus_err_m), 32'd0);
      if (in_req) begin
        check_val("req_addr", mem_addr, {addr[31:2], 2'b00});
        check_val("req_we", 32'(mem_we), 32'(mw));
        check_val("req_be", 32'(mem_be), 32'(ref_be(mw, f3, addr)));
        if (mw) check_val("req_wdata", mem_wdata, ref_wdata(f3, wd));
      end
      next_cycle();
    end
    mem_gnt = 1'b0;
    mem_rvalid = ($urandom_range(0, 1) == 0);
    mem_rdata  = $urandom;
    @(negedge clk);
    last_rd = exp_q.pop_front();
    check_val("end_stall", 32'(stall_lsu), 32'd0);
    check_val("end_req", 32'(mem_req), 32'd0);
    check_val("end_buserr", 32'(bus_err_m), 32'(!ok_bus));
    check_val("end_rdata", read_data_m, last_rd);
    next_cycle();
    idle_inputs();
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    @(negedge clk);
    check_val("after_buserr", 32'(bus_err_m), 32'd0);
    check_val("after_rd_hold", read_data_m, last_rd);
    check_val("after_stall", 32'(stall_lsu), 32'd0);
    check_val("after_req", 32'(mem_req), 32'd0);
    next_cycle();
    mem_rvalid = 1'b0;
  endtask

  task automatic reset_in_wait();
    mem_write_m = 1'b0; result_src_m = 2'b01; funct3_m = 3'b010; alu_result_m = 32'h100;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    next_cycle();
    idle_inputs();
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_wait_stall", 32'(stall_lsu), 32'd0);
    check_val("rst_wait_req", 32'(mem_req), 32'd0);
    next_cycle();
    reset = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    check_val("rst_late_rd", read_data_m, 32'd0);
    check_val("rst_late_stall", 32'(stall_lsu), 32'd0);
    check_val("rst_late_buserr", 32'(bus_err_m), 32'd0);
    check_val("rst_late_exc", 32'(lsu_exc_m), 32'd0);
    check_val("rst_late_req", 32'(mem_req), 32'd0);
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_val("rst_post_rd", read_data_m, 32'd0);
    check_val("rst_post_buserr", 32'(bus_err_m), 32'd0);
    check_val("rst_post_stall", 32'(stall_lsu), 32'd0);
    last_rd = 32'd0;
    next_cycle();
  endtask

  initial begin
    logic        mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          kind;
    reset = 1'b1;
    idle_inputs();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (2) next_cycle();
    result_src_m = 2'b01; funct3_m = 3'b010; alu_result_m = 32'h100;
    @(negedge clk);
    check_val("rst_stall", 32'(stall_lsu), 32'd0);
    check_val("rst_req", 32'(mem_req), 32'd0);
    check_val("rst_exc", 32'(lsu_exc_m), 32'd0);
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_rdata", read_data_m, 32'd0);
    check_val("rst_buserr", 32'(bus_err_m), 32'd0);
    check_val("rst_req_out", 32'(mem_req), 32'd0);
    check_val("rst_stall_out", 32'(stall_lsu), 32'd0);
    next_cycle();

    do_access(1'b0, 2'b01, 3'b010, 32'h100, 32'd0, 0, 1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    do_access(1'b0, 2'b01, 3'b000, 32'h103, 32'd0, 1, 0, 32'h80FFFF7F, 1'b1, 32'hFFFFFF80);
    do_access(1'b0, 2'b01, 3'b100, 32'h103, 32'd0, 0, 2, 32'h80FFFF7F, 1'b1, 32'h00000080);
    do_access(1'b1, 2'b00, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 32'd0, 1'b1, 32'd0);
    do_access(1'b0, 2'b01, 3'b010, 32'h101, 32'd0, 0, 0, 32'd0, 1'b0, 32'd0);
    do_access(1'b1, 2'b00, 3'b010, 32'h300, 32'hCAFEF00D, 99, 0, 32'd0, 1'b1, 32'd0);
    do_access(1'b1, 2'b00, 3'b010, 32'h300, 32'hCAFEF00D, TO, 0, 32'd0, 1'b1, 32'd0);
    do_access(1'b0, 2'b01, 3'b010, 32'h400, 32'd0, 0, 0, 32'h13579BDF, 1'b1, 32'h13579BDF);
    reset_in_wait();

    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       begin mw = 1'b1; rs = 2'($urandom_range(0, 3)); end
        1:       begin mw = 1'b0; rs = 2'b01; end
        2:       begin mw = 1'b0; rs = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b1x; end
        default: begin mw = 1'b1; rs = 2'b01; end
      endcase
      if (rs === 2'b1x) rs = 2'($urandom_range(2, 3));
      f3   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      addr = $urandom;
      do_access(mw, rs, f3, addr, $urandom, $urandom_range(0, TO + 2), $urandom_range(0, 5),
                $urandom, 1'b0, 32'd0);
    end

    check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
